// File: rtl/video_timing_gen_if.sv
// Video timing bundle: run enable into the generator, sync/blank/position strobes out.
interface video_timing_if #(
  parameter int unsigned X_BITS = 12,
  parameter int unsigned Y_BITS = 12
);
  logic              en;
  logic              hs_out;
  logic              vs_out;
  logic              de_out;
  logic [X_BITS-1:0] act_x;
  logic [Y_BITS-1:0] act_y;
  logic              frame_start;

  modport master (
    input  en,
    output hs_out, vs_out, de_out, act_x, act_y, frame_start
  );

  modport slave (
    output en,
    input  hs_out, vs_out, de_out, act_x, act_y, frame_start
  );
endinterface

// File: rtl/video_timing_gen.sv
// Raster timing generator: h/v counters decoded into registered sync, blank and
// active-pixel coordinates, all aligned one pix_clk behind the counter state.
module video_timing_gen #(
  parameter int unsigned X_BITS = 12,
  parameter int unsigned Y_BITS = 12,
  parameter int unsigned H_ACT  = 1280,
  parameter int unsigned H_FP   = 110,
  parameter int unsigned H_SYNC = 40,
  parameter int unsigned H_BP   = 220,
  parameter int unsigned V_ACT  = 720,
  parameter int unsigned V_FP   = 5,
  parameter int unsigned V_SYNC = 5,
  parameter int unsigned V_BP   = 20,
  parameter bit          HS_POL = 1'b1,
  parameter bit          VS_POL = 1'b1
) (
  input  logic           pix_clk,
  input  logic           rstn,
  video_timing_if.master vid
);

  localparam int unsigned H_TOTAL     = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int unsigned V_TOTAL     = V_SYNC + V_BP + V_ACT + V_FP;
  localparam int unsigned H_ACT_START = H_SYNC + H_BP;
  localparam int unsigned H_ACT_END   = H_ACT_START + H_ACT;
  localparam int unsigned V_ACT_START = V_SYNC + V_BP;
  localparam int unsigned V_ACT_END   = V_ACT_START + V_ACT;

  logic [X_BITS-1:0] h_cnt_q, h_cnt_d;
  logic [Y_BITS-1:0] v_cnt_q, v_cnt_d;
  logic              hs_q, hs_d;
  logic              vs_q, vs_d;
  logic              de_q, de_d;
  logic [X_BITS-1:0] act_x_q, act_x_d;
  logic [Y_BITS-1:0] act_y_q, act_y_d;
  logic              fs_q, fs_d;
  logic              h_act, v_act;

  // Counter advance and region decode; en low clears counters and idles outputs.
  always_comb begin
    h_act   = (h_cnt_q >= X_BITS'(H_ACT_START)) && (h_cnt_q < X_BITS'(H_ACT_END));
    v_act   = (v_cnt_q >= Y_BITS'(V_ACT_START)) && (v_cnt_q < Y_BITS'(V_ACT_END));
    h_cnt_d = '0;
    v_cnt_d = '0;
    hs_d    = ~HS_POL;
    vs_d    = ~VS_POL;
    de_d    = 1'b0;
    act_x_d = '0;
    act_y_d = '0;
    fs_d    = 1'b0;
    if (vid.en) begin
      if (h_cnt_q == X_BITS'(H_TOTAL - 1)) begin
        if (v_cnt_q != Y_BITS'(V_TOTAL - 1)) begin
          v_cnt_d = v_cnt_q + Y_BITS'(1);
        end
      end else begin
        h_cnt_d = h_cnt_q + X_BITS'(1);
        v_cnt_d = v_cnt_q;
      end
      hs_d    = (h_cnt_q < X_BITS'(H_SYNC)) ? HS_POL : ~HS_POL;
      vs_d    = (v_cnt_q < Y_BITS'(V_SYNC)) ? VS_POL : ~VS_POL;
      de_d    = h_act && v_act;
      act_x_d = h_act ? (h_cnt_q - X_BITS'(H_ACT_START)) : '0;
      act_y_d = v_act ? (v_cnt_q - Y_BITS'(V_ACT_START)) : '0;
      fs_d    = (h_cnt_q == '0) && (v_cnt_q == '0);
    end
  end

  always_ff @(posedge pix_clk or negedge rstn) begin
    if (!rstn) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      hs_q    <= ~HS_POL;
      vs_q    <= ~VS_POL;
      de_q    <= 1'b0;
      act_x_q <= '0;
      act_y_q <= '0;
      fs_q    <= 1'b0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      de_q    <= de_d;
      act_x_q <= act_x_d;
      act_y_q <= act_y_d;
      fs_q    <= fs_d;
    end
  end

  assign vid.hs_out      = hs_q;
  assign vid.vs_out      = vs_q;
  assign vid.de_out      = de_q;
  assign vid.act_x       = act_x_q;
  assign vid.act_y       = act_y_q;
  assign vid.frame_start = fs_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: reduced raster, two polarities side by side, checked
// every cycle against a position-based frame model plus whole-frame statistics.
module tb_video_timing_gen;

  localparam int unsigned XB = 8;
  localparam int unsigned YB = 6;
  localparam int unsigned HA = 20, HF = 3, HS = 4, HB = 5;
  localparam int unsigned VA = 8,  VF = 2, VS = 2, VB = 3;
  localparam int unsigned HT = HS + HB + HA + HF;
  localparam int unsigned VT = VS + VB + VA + VF;
  localparam int unsigned FR = HT * VT;
  localparam int unsigned W1 = 4 + XB + YB;
  localparam int unsigned OW = 2 * W1;

  logic pix_clk = 1'b0;
  logic rstn    = 1'b0;
  logic en      = 1'b1;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int pos    = 0;
  logic [OW-1:0] exp_v;

  video_timing_if #(.X_BITS(XB), .Y_BITS(YB)) vif_p ();
  video_timing_if #(.X_BITS(XB), .Y_BITS(YB)) vif_n ();
  assign vif_p.en = en;
  assign vif_n.en = en;

  video_timing_gen #(
    .X_BITS(XB), .Y_BITS(YB),
    .H_ACT(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACT(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut_p (
    .pix_clk(pix_clk),
    .rstn   (rstn),
    .vid    (vif_p)
  );

  video_timing_gen #(
    .X_BITS(XB), .Y_BITS(YB),
    .H_ACT(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACT(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut_n (
    .pix_clk(pix_clk),
    .rstn   (rstn),
    .vid    (vif_n)
  );

  always #5 pix_clk = ~pix_clk;

  // Expected outputs for the p-th enabled cycle since the raster (re)started.
  function automatic logic [W1-1:0] model_one(int unsigned p, bit hp, bit vp, bit idle);
    int unsigned col, line;
    bit ha, va, hs, vs, fs;
    logic [XB-1:0] ax;
    logic [YB-1:0] ay;
    if (idle) return {~hp, ~vp, 1'b0, 1'b0, XB'(0), YB'(0)};
    col  = p % HT;
    line = (p / HT) % VT;
    ha   = (col >= HS + HB) && (col < HS + HB + HA);
    va   = (line >= VS + VB) && (line < VS + VB + VA);
    hs   = (col < HS) ? hp : ~hp;
    vs   = (line < VS) ? vp : ~vp;
    fs   = (p % FR) == 0;
    ax   = ha ? XB'(col - (HS + HB)) : XB'(0);
    ay   = va ? YB'(line - (VS + VB)) : YB'(0);
    return {hs, vs, ha && va, fs, ax, ay};
  endfunction

  function automatic logic [OW-1:0] obs();
    return {vif_p.hs_out, vif_p.vs_out, vif_p.de_out, vif_p.frame_start, vif_p.act_x, vif_p.act_y,
            vif_n.hs_out, vif_n.vs_out, vif_n.de_out, vif_n.frame_start, vif_n.act_x, vif_n.act_y};
  endfunction

  // Advance one clock and update the model; leaves time 1 unit after the edge.
  task automatic tick();
    @(posedge pix_clk);
    if (!rstn || !en) begin
      exp_v = {model_one(0, 1'b1, 1'b1, 1'b1), model_one(0, 1'b0, 1'b0, 1'b1)};
      pos   = 0;
    end else begin
      exp_v = {model_one(pos, 1'b1, 1'b1, 1'b0), model_one(pos, 1'b0, 1'b0, 1'b0)};
      pos++;
    end
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    en   = 1'b1;
    repeat (3) tick();
    checks++;
    if (obs() !== exp_v) begin
      errors++;
      $display("FAIL reset_idle cyc=%0d got=%h exp=%h", cyc, obs(), exp_v);
    end
    rstn = 1'b1;
    tick();
    checks++;
    if (vif_p.frame_start !== 1'b1 || vif_n.frame_start !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_fs got=%b/%b exp=1", vif_p.frame_start, vif_n.frame_start);
    end
    checks++;
    if (obs() !== exp_v) begin
      errors++;
      $display("FAIL reset_first_cycle got=%h exp=%h", obs(), exp_v);
    end
  endtask

  task automatic test_frame_timing();
    int f_idx = 0, fs0 = 0, period = -1, rel;
    int hs_cnt = 0, hsn_cnt = 0, vs_cnt = 0, de_cnt = 0, first_de = -1;
    int last_x = -1, last_y = -1;
    for (int i = 0; i < int'(2 * FR + HT); i++) begin
      tick();
      checks++;
      if (obs() !== exp_v) begin
        errors++;
        if (errors < 20) $display("FAIL frame_cycle cyc=%0d got=%h exp=%h", cyc, obs(), exp_v);
      end
      if (vif_p.frame_start) begin
        if (f_idx == 1) period = cyc - fs0;
        if (f_idx == 0) fs0 = cyc;
        f_idx++;
      end
      if (f_idx == 1) begin
        rel = cyc - fs0;
        if (rel < int'(HT) && vif_p.hs_out) hs_cnt++;
        if (rel < int'(HT) && !vif_n.hs_out) hsn_cnt++;
        if (vif_p.vs_out) vs_cnt++;
        if (vif_p.de_out) begin
          de_cnt++;
          if (first_de < 0) first_de = rel;
          last_x = int'(vif_p.act_x);
          last_y = int'(vif_p.act_y);
        end
      end
    end
    checks++;
    if (period != int'(FR)) begin
      errors++; $display("FAIL fs_period got=%0d exp=%0d", period, FR);
    end
    checks++;
    if (hs_cnt != int'(HS) || hsn_cnt != int'(HS)) begin
      errors++; $display("FAIL hs_width got=%0d/%0d exp=%0d", hs_cnt, hsn_cnt, HS);
    end
    checks++;
    if (vs_cnt != int'(VS * HT)) begin
      errors++; $display("FAIL vs_width got=%0d exp=%0d", vs_cnt, VS * HT);
    end
    checks++;
    if (de_cnt != int'(HA * VA)) begin
      errors++; $display("FAIL de_total got=%0d exp=%0d", de_cnt, HA * VA);
    end
    checks++;
    if (first_de != int'((VS + VB) * HT + HS + HB)) begin
      errors++; $display("FAIL first_de got=%0d exp=%0d", first_de, (VS + VB) * HT + HS + HB);
    end
    checks++;
    if (last_x != int'(HA - 1) || last_y != int'(VA - 1)) begin
      errors++; $display("FAIL last_pixel got=%0d,%0d exp=%0d,%0d", last_x, last_y, HA - 1, VA - 1);
    end
  endtask

  task automatic test_en_drop();
    int budget = int'(FR) + 10;
    int gap;
    while (!(vif_p.de_out && vif_p.act_y == YB'(4) && vif_p.act_x == XB'(7)) && budget > 0) begin
      tick();
      budget--;
    end
    checks++;
    if (budget == 0) begin
      errors++; $display("FAIL en_drop_wait got=timeout exp=act_y 4");
    end
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (obs() !== exp_v) begin
        errors++; $display("FAIL en_low_idle cyc=%0d got=%h exp=%h", cyc, obs(), exp_v);
      end
    end
    en = 1'b1;
    tick();
    checks++;
    if (vif_p.frame_start !== 1'b1 || vif_n.frame_start !== 1'b1 || obs() !== exp_v) begin
      errors++; $display("FAIL en_restart_fs got=%h exp=%h", obs(), exp_v);
    end
    gap = 0;
    for (int i = 0; i < int'(FR); i++) begin
      tick();
      gap++;
      checks++;
      if (obs() !== exp_v) begin
        errors++;
        if (errors < 20) $display("FAIL en_restart_cycle cyc=%0d got=%h exp=%h", cyc, obs(), exp_v);
      end
      if (vif_p.frame_start) break;
    end
    checks++;
    if (gap != int'(FR) || vif_p.frame_start !== 1'b1) begin
      errors++; $display("FAIL en_restart_period got=%0d exp=%0d", gap, FR);
    end
  endtask

  task automatic test_reset_midframe();
    int budget = int'(FR) + 10;
    while (!(vif_p.de_out && vif_p.act_y == YB'(5) && vif_p.act_x == XB'(10)) && budget > 0) begin
      tick();
      budget--;
    end
    checks++;
    if (budget == 0) begin
      errors++; $display("FAIL rst_mid_wait got=timeout exp=act 10,5");
    end
    #2;
    rstn = 1'b0;
    #1;
    exp_v = {model_one(0, 1'b1, 1'b1, 1'b1), model_one(0, 1'b0, 1'b0, 1'b1)};
    pos   = 0;
    checks++;
    if (obs() !== exp_v) begin
      errors++; $display("FAIL rst_async_idle got=%h exp=%h", obs(), exp_v);
    end
    repeat (2) tick();
    rstn = 1'b1;
    for (int i = 0; i < int'(FR) + 1; i++) begin
      tick();
      checks++;
      if (obs() !== exp_v) begin
        errors++;
        if (errors < 20) $display("FAIL rst_restart_cycle cyc=%0d got=%h exp=%h", cyc, obs(), exp_v);
      end
    end
    checks++;
    if (vif_p.frame_start !== 1'b1) begin
      errors++; $display("FAIL rst_restart_period got=%b exp=1", vif_p.frame_start);
    end
  endtask

  task automatic test_random_en();
    int low_left = 0;
    for (int i = 0; i < 3 * int'(FR); i++) begin
      if (low_left > 0) begin
        low_left--;
        en = (low_left == 0);
      end else if ($urandom_range(0, 60) == 0) begin
        low_left = int'($urandom_range(1, 6));
        en = 1'b0;
      end
      tick();
      checks++;
      if (obs() !== exp_v) begin
        errors++;
        if (errors < 20) $display("FAIL random_en cyc=%0d en=%b got=%h exp=%h", cyc, en, obs(), exp_v);
      end
    end
    en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_frame_timing();
    test_en_drop();
    test_reset_midframe();
    test_random_en();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 X_BITS, 12, width of h counter and act_x.
REQ-002 Y_BITS, 12, width of v counter and act_y.
REQ-003 H_ACT/H_FP/H_SYNC/H_BP, 1280/110/40/220, horizontal active, front porch, sync and back porch in pixels.
REQ-004 V_ACT/V_FP/V_SYNC/V_BP, 720/5/5/20, vertical active, front porch, sync and back porch in lines.
REQ-005 HS_POL/VS_POL, 1/1, active level of hs_out/vs_out.
REQ-006 pix_clk  in  1  pixel clock; all logic on its rising edge.
REQ-007 rstn  in  1  reset, asynchronous, active-low.
REQ-008 en  in  1  timing run enable; low holds the generator idle.
REQ-009 hs_out  out  1  horizontal sync at HS_POL during sync region.
REQ-010 vs_out  out  1  vertical sync at VS_POL during sync lines.
REQ-011 de_out  out  1  high only inside active picture.
REQ-012 act_x  out  X_BITS  active-pixel column, 0..H_ACT-1.
REQ-013 act_y  out  Y_BITS  active-pixel row, 0..V_ACT-1.
REQ-014 frame_start  out  1  one-cycle pulse on first pixel clock of each frame.

Function
REQ-015 Derived totals: H_TOTAL = H_SYNC+H_BP+H_ACT+H_FP, V_TOTAL = V_SYNC+V_BP+V_ACT+V_FP; 720p defaults give 1650 and 750.
REQ-016 h_cnt counts 0..H_TOTAL-1 and wraps to 0; v_cnt increments only on h_cnt wrap and wraps to 0 after V_TOTAL-1.
REQ-017 Line order: sync h_cnt 0..H_SYNC-1, back porch, active h_cnt H_SYNC+H_BP..H_SYNC+H_BP+H_ACT-1, front porch.
REQ-018 Frame order identical on v_cnt: sync lines 0..V_SYNC-1, back porch, active lines V_SYNC+V_BP..V_SYNC+V_BP+V_ACT-1, front porch.
REQ-019 All outputs are registered, one pix_clk after the counter state they decode; all outputs are mutually cycle-aligned.
REQ-020 vs_out changes only at h_cnt = 0 boundaries.
REQ-021 de_out = horizontal-active AND vertical-active.
REQ-022 act_x = h_cnt-(H_SYNC+H_BP) while horizontal-active, else 0; act_y = v_cnt-(V_SYNC+V_BP) while vertical-active, else 0.
REQ-023 frame_start high for exactly the cycle decoding h_cnt=0, v_cnt=0.
REQ-024 Counter subtraction uses full X_BITS/Y_BITS width; no act_x/act_y value outside its active range is ever emitted.
REQ-025 en low: counters synchronously cleared to 0; outputs forced idle (hs_out=~HS_POL, vs_out=~VS_POL, de_out=0, act_x=0, act_y=0, frame_start=0) from the next cycle.
REQ-026 en rising: first enabled cycle decodes h_cnt=0, v_cnt=0, so frame_start asserts one cycle later; en deassert mid-frame aborts the frame with no partial-line continuation.

Reset
REQ-027 rstn low asynchronously clears h_cnt, v_cnt to 0 and drives all outputs to idle values per REQ-025.
REQ-028 After rstn release with en high, the first rising edge decodes h_cnt=0, v_cnt=0; frame_start asserts on the following cycle.
REQ-029 Reset asserted mid-frame takes effect immediately without waiting for line or frame end.

Verification
REQ-030 Defaults, en=1 after reset -> hs_out high 40 cycles per 1650-cycle line; vs_out high 5 lines (8250 cycles) per frame.
REQ-031 Full frame -> frame_start period exactly 1,237,500 cycles; de_out high 1280 cycles per active line across 720 lines, 921,600 cycles total.
REQ-032 First de_out of frame -> occurs 25 lines + 260 cycles after frame_start with act_x=0, act_y=0; last active pixel act_x=1279, act_y=719; act_x/act_y read 0 whenever de_out=0.
REQ-033 HS_POL=0, VS_POL=0 -> sync waveforms inverted; de_out, act_x, act_y unchanged.
REQ-034 en dropped at act_y=300, held low 100 cycles, raised -> idle outputs during low period; frame_start one cycle after first enabled edge; next frame timing matches REQ-031.
REQ-035 rstn pulsed low at act_x=640, act_y=412 -> outputs idle same cycle; full timing restarts from frame_start per REQ-028.
